// File: rtl/grad_vec_packer.sv
// Packs a serial stream of 32-bit gradient words into WIDTH-lane vectors.
// The fill and output registers form a double buffer; a short tail is zero-padded and flagged.
module grad_vec_packer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [31:0]              out_vec [WIDTH],
  output logic                     out_valid,
  output logic                     out_last,
  output logic [$clog2(WIDTH):0]   out_count,
  input  logic                     out_ready
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [0:0] {StFill, StPend} state_e;

  state_e          r_state;
  state_e          w_state_d;

  logic [31:0]     r_fill [WIDTH];
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_pend_count;
  logic            r_pend_last;

  logic [31:0]     r_out_vec [WIDTH];
  logic            r_out_valid;
  logic            r_out_last;
  logic [CW-1:0]   r_out_count;

  logic            w_accept;
  logic            w_complete;
  logic            w_osf;
  logic            w_load_fill;
  logic            w_load_pend;
  logic            w_to_pend;
  logic [31:0]     w_cvec [WIDTH];
  logic [CW-1:0]   w_ccount;

  assign w_accept    = in_valid && in_ready;
  assign w_complete  = w_accept && ((r_idx == IW'(WIDTH - 1)) || in_last);
  assign w_osf       = !r_out_valid || out_ready;
  assign w_load_fill = (r_state == StFill) && w_complete && w_osf;
  assign w_load_pend = (r_state == StPend) && w_osf;
  assign w_to_pend   = (r_state == StFill) && w_complete && !w_osf;
  assign w_ccount    = CW'(r_idx) + CW'(1);

  // Lanes above the completing word are forced to zero so a short tail is padded.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_cvec[i] = 32'h0;
      if (IW'(i) < r_idx) begin
        w_cvec[i] = r_fill[i];
      end else if (IW'(i) == r_idx) begin
        w_cvec[i] = in_data;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StFill;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StFill: if (w_to_pend) w_state_d = StPend;
      StPend: if (w_osf) w_state_d = StFill;
      default: w_state_d = StFill;
    endcase
  end

  // Output logic: registered state only, so no out_ready -> in_ready path.
  always_comb begin
    in_ready = reset && (r_state == StFill);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) r_fill[i] <= 32'h0;
      r_idx        <= '0;
      r_pend_count <= '0;
      r_pend_last  <= 1'b0;
    end else if (w_load_fill || w_load_pend) begin
      for (int i = 0; i < WIDTH; i++) r_fill[i] <= 32'h0;
      r_idx <= '0;
    end else if (w_to_pend) begin
      r_fill       <= w_cvec;
      r_pend_count <= w_ccount;
      r_pend_last  <= in_last;
    end else if (w_accept) begin
      r_fill[r_idx] <= in_data;
      r_idx         <= r_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) r_out_vec[i] <= 32'h0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_count <= '0;
    end else if (w_load_fill) begin
      r_out_vec   <= w_cvec;
      r_out_valid <= 1'b1;
      r_out_last  <= in_last;
      r_out_count <= w_ccount;
    end else if (w_load_pend) begin
      r_out_vec   <= r_fill;
      r_out_valid <= 1'b1;
      r_out_last  <= r_pend_last;
      r_out_count <= r_pend_count;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_vec   = r_out_vec;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_count = r_out_count;

endmodule
